// File: rtl/udma_smi_slave.sv
// -----------------------------------------------------------------------------
// udma_smi_slave
//   PHY-side MDIO/SMI responder for Clause-22 frames. MDC/MDIO are oversampled
//   on clk_i. Each synced MDC rising edge produces one "bit" cycle. On that
//   cycle the synced MDIO is sampled and all outputs update.
//   Decodes preamble/ST/OP/PHYAD/REGAD/TA/DATA. Read data is driven back on
//   MDIO. Accesses are presented on a simple register-file port.
//
//   Optional build macro:
//     SMI_SLV_PREAMBLE_SUPPRESS_EN - in IDLE, accept ST after a single sampled 1
//                                    instead of PREAMBLE_LEN consecutive 1s.
//
// Ports:
//   clk_i, rstn_i         system clock (>= 4x MDC), async active-low reset
//   mdc_i, mdio_i         management clock / MDIO pad input (async to clk_i)
//   mdio_o, mdio_oe_o     MDIO output data / output enable
//   phy_addr_i            this device's PHY address (quasi-static)
//   reg_addr_o            register address of the current matched frame
//   reg_rd_o              1-cycle read strobe; reg_rd_data_i is combinational
//                         from reg_addr_o
//   reg_wr_o              1-cycle write strobe; reg_wr_data_o holds afterwards
//   frame_err_o           1-cycle pulse on malformed ST/OP
//   busy_o                high from the first ST bit until the return to IDLE
// -----------------------------------------------------------------------------
module udma_smi_slave #(
    parameter int SYNC_STAGES  = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic [4:0]  phy_addr_i,
    output logic [4:0]  reg_addr_o,
    output logic        reg_rd_o,
    input  logic [15:0] reg_rd_data_i,
    output logic        reg_wr_o,
    output logic [15:0] reg_wr_data_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    localparam int              PW      = $clog2(PREAMBLE_LEN + 1);
    localparam logic [PW-1:0]   PRE_MAX = PW'(PREAMBLE_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] mdc_sync, mdio_sync;
    logic                   mdc_prev;
    logic                   bit_en, bit_val;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mdc_sync  <= '0;
            mdio_sync <= '0;
            mdc_prev  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[SYNC_STAGES-2:0], mdc_i};
            mdio_sync <= {mdio_sync[SYNC_STAGES-2:0], mdio_i};
            mdc_prev  <= mdc_sync[SYNC_STAGES-1];
        end
    end

    assign bit_en  = mdc_sync[SYNC_STAGES-1] & ~mdc_prev;
    assign bit_val = mdio_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------------- state
    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    // One shift register serves OP/PHYAD/REGAD capture, write data in, and
    // read data out. These uses never overlap within a frame.
    logic [15:0]   sr_q, sr_d;
    logic          rd_op_q, rd_op_d;
    logic          match_q, match_d;
    logic [4:0]    reg_addr_d;
    logic          mdio_d, oe_d, rd_d, wr_d, err_d;
    logic [15:0]   wr_data_d;
    logic          start_ok;

`ifdef SMI_SLV_PREAMBLE_SUPPRESS_EN
    assign start_ok = (pcnt_q != '0);
`else
    assign start_ok = (pcnt_q == PRE_MAX);
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= S_IDLE;
            pcnt_q        <= '0;
            bcnt_q        <= '0;
            sr_q          <= '0;
            rd_op_q       <= 1'b0;
            match_q       <= 1'b0;
            reg_addr_o    <= '0;
            mdio_o        <= 1'b0;
            mdio_oe_o     <= 1'b0;
            reg_rd_o      <= 1'b0;
            reg_wr_o      <= 1'b0;
            reg_wr_data_o <= '0;
            frame_err_o   <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            bcnt_q        <= bcnt_d;
            sr_q          <= sr_d;
            rd_op_q       <= rd_op_d;
            match_q       <= match_d;
            reg_addr_o    <= reg_addr_d;
            mdio_o        <= mdio_d;
            mdio_oe_o     <= oe_d;
            reg_rd_o      <= rd_d;
            reg_wr_o      <= wr_d;
            reg_wr_data_o <= wr_data_d;
            frame_err_o   <= err_d;
            busy_o        <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        bcnt_d     = bcnt_q;
        sr_d       = sr_q;
        rd_op_d    = rd_op_q;
        match_d    = match_q;
        reg_addr_d = reg_addr_o;
        mdio_d     = mdio_o;
        oe_d       = mdio_oe_o;
        wr_data_d  = reg_wr_data_o;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        err_d      = 1'b0;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (bit_val) begin
                        if (pcnt_q != PRE_MAX) pcnt_d = pcnt_q + 1'b1;
                    end else begin
                        pcnt_d = '0;
                        if (start_ok) state_d = S_ST2;
                    end
                end
                S_ST2: begin
                    bcnt_d = '0;
                    if (bit_val) begin
                        state_d = S_OP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                        pcnt_d  = '0;
                    end
                end
                S_OP: begin
                    if (bcnt_q == 4'd0) begin
                        sr_d   = {sr_q[14:0], bit_val};
                        bcnt_d = 4'd1;
                    end else begin
                        bcnt_d = '0;
                        case ({sr_q[0], bit_val})
                            2'b10: begin rd_op_d = 1'b1; state_d = S_PHYAD; end
                            2'b01: begin rd_op_d = 1'b0; state_d = S_PHYAD; end
                            default: begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                                pcnt_d  = '0;
                            end
                        endcase
                    end
                end
                S_PHYAD: begin
                    sr_d = {sr_q[14:0], bit_val};
                    if (bcnt_q == 4'd4) begin
                        match_d = ({sr_q[3:0], bit_val} == phy_addr_i);
                        state_d = S_REGAD;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                S_REGAD: begin
                    sr_d = {sr_q[14:0], bit_val};
                    if (bcnt_q == 4'd4) begin
                        if (match_q) reg_addr_d = {sr_q[3:0], bit_val};
                        state_d = S_TA;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                S_TA: begin
                    // Read data is latched on TA1, so reg_rd_data_i only has
                    // to be valid for the address registered one bit earlier.
                    if (rd_op_q && match_q) begin
                        if (bcnt_q == 4'd0) begin
                            rd_d   = 1'b1;
                            sr_d   = reg_rd_data_i;
                            oe_d   = 1'b1;
                            mdio_d = 1'b0;
                        end else begin
                            mdio_d = sr_q[15];
                            sr_d   = {sr_q[14:0], 1'b0};
                        end
                    end
                    if (bcnt_q == 4'd0) begin
                        bcnt_d = 4'd1;
                    end else begin
                        bcnt_d  = '0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    // bcnt_q counts data slots 1..16 as 0..15.
                    if (rd_op_q) begin
                        if (match_q) begin
                            if (bcnt_q == 4'd15) begin
                                oe_d   = 1'b0;
                                mdio_d = 1'b0;
                            end else begin
                                mdio_d = sr_q[15];
                                sr_d   = {sr_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        sr_d = {sr_q[14:0], bit_val};
                        if (bcnt_q == 4'd15 && match_q) begin
                            wr_data_d = {sr_q[14:0], bit_val};
                            wr_d      = 1'b1;
                        end
                    end
                    if (bcnt_q == 4'd15) begin
                        state_d = S_IDLE;
                        pcnt_d  = '0;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
